// File: rtl/array_scatter_if.sv
// Bus bundle for array_scatter: narrow word input stream, frame select and
// flush controls, and the wide frame output with its own handshake.
//   Sel, Flush        : frame fill order / discard request (producer -> block)
//   In_Valid/In_Ready : narrow word handshake, In_Data carries the word
//   Out_Valid/Out_Ready: wide frame handshake, Output carries the frame
//   Count             : words accepted in the current frame
// The block uses the slave modport, the traffic source uses the master one.
interface array_scatter_if #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 16
);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS) + 1;
    localparam int unsigned OUT_W = WORD_W * NUM_WORDS;

    logic              Sel;
    logic              Flush;
    logic              In_Valid;
    logic              In_Ready;
    logic [WORD_W-1:0] In_Data;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [OUT_W-1:0]  Output;
    logic [CNT_W-1:0]  Count;

    modport master (
        output Sel, Flush, In_Valid, In_Data, Out_Ready,
        input  In_Ready, Out_Valid, Output, Count
    );

    modport slave (
        input  Sel, Flush, In_Valid, In_Data, Out_Ready,
        output In_Ready, Out_Valid, Output, Count
    );
endinterface

// File: rtl/array_scatter.sv
// Word-to-array assembler. Collects NUM_WORDS words of WORD_W bits from a
// valid/ready stream and scatters them into a wide frame register, filling
// slots ascending (order 0) or mirrored/descending (order 1). The order is
// taken from Sel on the first word of each frame and held for the rest.
// Ports:
//   Clock  : rising-edge clock
//   Resetn : synchronous active-low reset
//   bus    : array_scatter_if slave (Sel, Flush, In_*, Out_*, Output, Count)
module array_scatter #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 16
) (
    input  logic            Clock,
    input  logic            Resetn,
    array_scatter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned OUT_W = WORD_W * NUM_WORDS;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               sel_q,   sel_d;
    logic [OUT_W-1:0]   data_q,  data_d;

    logic               in_ready;
    logic               accept;
    logic               order;
    logic [IDX_W-1:0]   slot;

    // State and datapath registers; reset overrides flush, accept and release.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    // Next-state and slot-write logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        accept  = bus.In_Valid && in_ready;
        // First word of a frame follows live Sel; later words the captured bit.
        order   = (cnt_q == '0) ? bus.Sel : sel_q;
        // NUM_WORDS is a power of two, so NUM_WORDS-1-k is the bitwise inverse of k.
        slot    = order ? ~cnt_q[IDX_W-1:0] : cnt_q[IDX_W-1:0];

        if (bus.Flush) begin
            // Flush wins over accept and release; partial words stay in data_q.
            state_d = FILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            sel_d = bus.Sel;
                        end
                        for (int unsigned s = 0; s < NUM_WORDS; s++) begin
                            if (slot == IDX_W'(s)) begin
                                data_d[s*WORD_W +: WORD_W] = bus.In_Data;
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    // Release; Count wraps here, never by increment.
                    if (bus.Out_Ready) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // Outputs: In_Ready is combinational, the rest come straight from registers.
    always_comb begin
        in_ready      = (state_q == FILL) && !bus.Flush;
        bus.In_Ready  = in_ready;
        bus.Out_Valid = (state_q == FULL);
        bus.Output    = data_q;
        bus.Count     = cnt_q;
    end
endmodule

// File: doc/array_scatter.md
Name: array_scatter

Overview:
- Word-to-array assembler: accepts a stream of WORD_W-bit words over a valid/ready handshake and scatters them into a NUM_WORDS-slot wide output register.
- Each frame's fill order is chosen by Sel: ascending, or mirrored/descending.
- Presents the completed wide frame with its own valid/ready handshake.
- Sits on the producer side of the wide array bus, rebuilding wide vectors from narrow per-cycle words.

Parameters:
- WORD_W, 32, width of one input word.
- NUM_WORDS, 16, words per frame. Must be a power of two, >= 2. Output width is WORD_W*NUM_WORDS (512 at defaults).

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  synchronous active-low reset, sampled on rising edge of Clock.
- Sel  input  1  fill order for the next frame: 0 = ascending, 1 = descending (mirrored).
- Flush  input  1  synchronous discard of the current frame.
- In_Valid  input  1  In_Data is valid.
- In_Ready  output  1  block accepts a word this cycle.
- In_Data  input  WORD_W  input word.
- Out_Valid  output  1  Output holds a complete frame.
- Out_Ready  input  1  consumer takes the frame.
- Output  output  WORD_W*NUM_WORDS  assembled frame; slot s = Output[s*WORD_W +: WORD_W].
- Count  output  log2(NUM_WORDS)+1  words accepted in the current frame.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (Resetn, sampled on the rising edge of Clock); the reset port is Resetn.
- Reset values: state=FILL, Count=0, Output=0, Out_Valid=0, sel_q=0. In_Ready=1 in the first cycle after reset.
- States:
  - FILL: collecting words.
  - FULL: frame complete, awaiting consumer.
- Handshake signals:
  - In_Ready = (state==FILL) && !Flush, combinational.
  - Accept = In_Valid && In_Ready.
  - Out_Valid is registered, high exactly while state==FULL.
- Sel capture:
  - Sel is sampled into sel_q on the accept with Count==0 (first word of a frame).
  - Sel changes mid-frame are ignored until the next frame's first accept.
  - The first word of a frame uses the live Sel value directly.
- Slot mapping: the k-th accepted word (k = Count before increment) goes to slot k if the order bit is 0, or to slot NUM_WORDS-1-k if it is 1. Other slots are unchanged.
- Latency: a word appears on Output one cycle after its accept edge. Count increments on the same edge.
- Last word: an accept with Count==NUM_WORDS-1 sets Count=NUM_WORDS, state=FULL, Out_Valid=1 on that same edge. In_Ready drops in the following cycle.
- FULL state:
  - Output is held stable and no words are accepted.
  - On Out_Valid && Out_Ready: state=FILL, Count=0, Out_Valid=0 next edge.
  - Output keeps its old contents until overwritten slot by slot.
  - Earliest new accept is the cycle after the release (one bubble).
- Flush:
  - Has priority over accept and release in the same cycle.
  - In FILL: Count=0; the accepted partial words remain in Output (stale but harmless).
  - In FULL: Out_Valid=0, Count=0, state=FILL; the frame is dropped.
  - Flush with Count==0 in FILL has no effect.
- Resetn low mid-frame or in FULL: all reset values apply on that edge, overriding Flush, accept and release.
- Count never exceeds NUM_WORDS. It wraps only by the release or flush transition, never by increment.
- In_Data X is tolerated when In_Valid=0; Output changes only on accept or reset.

Test Plan:
1. Reset, Sel=0, stream words 0x00000000..0x0000000F with In_Valid held high -> Out_Valid rises at the edge of the 16th accept. Slot s=s, Output[31:0]=0x0, Output[511:480]=0xF, Count=16, In_Ready=0 next cycle.
2. Sel=1 at the first word, toggle Sel to 0 after word 3, stream 0xA0..0xAF -> slot 15=0xA0, slot 0=0xAF, full descending order kept despite the toggle.
3. Hold Out_Ready=0 for 5 cycles in FULL while In_Valid=1 -> Output stable, no accepts, Count=16. Raise Out_Ready for 1 cycle -> Out_Valid=0 and Count=0 next cycle; a new word is accepted one cycle later.
4. Accept 7 words, assert Flush together with In_Valid=1 -> that word is not accepted, In_Ready=0 that cycle, Count=0. The next frame of 16 words completes normally, with slot 0 set to the first post-flush word.
5. Accept 9 words, drive Resetn=0 for one cycle -> Output=0, Count=0, Out_Valid=0, state FILL. Resetn=0 asserted in FULL with Out_Ready=1 likewise yields reset values.
6. Random In_Valid/Out_Ready back-pressure over 100 frames with random Sel -> a scoreboard checks each frame's slot mapping, and no word is lost or duplicated.
